// File: rtl/hex_pkg.sv
// Shared types for the hex processor memory path: address/data widths,
// arbiter ownership tags and a little-endian byte selector.
package hex_pkg;

  localparam int unsigned WADDR_W     = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FETCH_BYTES = 4;

  typedef logic [WADDR_W-1:0] waddr_t;
  typedef logic [WADDR_W+1:0] iaddr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [7:0]         instr_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_F,
    OWNER_D
  } owner_e;

  typedef struct packed {
    owner_e     owner;
    logic [1:0] byte_sel;
  } resp_tag_t;

  function automatic instr_t sel_byte(input data_t word, input logic [1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arb_fetch_buf.sv
// One-word instruction fetch buffer for mem_arbiter (used only when
// HEX_FETCH_BUF_EN is defined): fill on fetch response, hit compare, write invalidate.
module mem_arb_fetch_buf
  import hex_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  waddr_t f_waddr,
  output logic   hit_raw,
  output data_t  buf_word,
  input  logic   fill_issue,
  input  logic   fill_done,
  input  data_t  fill_word,
  input  logic   wr_en,
  input  waddr_t wr_addr
);

  logic   buf_valid;
  waddr_t buf_addr;
  waddr_t pend_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_word  <= '0;
      pend_addr <= '0;
    end else begin
      if (fill_issue) pend_addr <= f_waddr;
      // A write to the word being filled this cycle makes the fill stale.
      if (fill_done) begin
        buf_valid <= !(wr_en && (wr_addr == pend_addr));
        buf_addr  <= pend_addr;
        buf_word  <= fill_word;
      end else if (wr_en && (wr_addr == buf_addr)) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign hit_raw = buf_valid && (buf_addr == f_waddr);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported hex memory: data-first priority with
// fetch anti-starvation, 1-cycle response routing. Optional buffer: HEX_FETCH_BUF_EN.
module mem_arbiter
  import hex_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_f_valid,
  output logic   o_f_ready,
  input  iaddr_t i_f_addr,
  output logic   o_f_rvalid,
  output instr_t o_f_data,
  input  logic   i_d_valid,
  output logic   o_d_ready,
  input  logic   i_d_we,
  input  waddr_t i_d_addr,
  input  data_t  i_d_data,
  output logic   o_d_rvalid,
  output data_t  o_d_data,
  output logic   o_m_valid,
  output logic   o_m_we,
  output waddr_t o_m_addr,
  output data_t  o_m_data,
  input  data_t  i_m_data
);

  logic [3:0] starve_cnt;
  logic       starved;
  resp_tag_t  tag_q, tag_d;
  waddr_t     f_waddr;
  logic       f_hit, hit_q;
  instr_t     hit_byte, hit_byte_q;
  logic       f_mem_gnt, d_gnt;
  instr_t     f_hold_q;
  data_t      d_hold_q;

  assign f_waddr = i_f_addr[WADDR_W+1:2];
  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

`ifdef HEX_FETCH_BUF_EN
  logic  hit_raw;
  data_t buf_word;

  mem_arb_fetch_buf u_fetch_buf (
    .clk        (i_clk),
    .rst        (i_rst),
    .f_waddr    (f_waddr),
    .hit_raw    (hit_raw),
    .buf_word   (buf_word),
    .fill_issue (f_mem_gnt),
    .fill_done  (tag_q.owner == OWNER_F),
    .fill_word  (i_m_data),
    .wr_en      (d_gnt && i_d_we),
    .wr_addr    (i_d_addr)
  );

  // Pending write to the same word demotes the hit so the fetch sees new data.
  assign f_hit    = !i_rst && i_f_valid && hit_raw &&
                    !(i_d_valid && i_d_we && (i_d_addr == f_waddr));
  assign hit_byte = sel_byte(buf_word, i_f_addr[1:0]);
`else
  assign f_hit    = 1'b0;
  assign hit_byte = '0;
`endif

  always_comb begin
    f_mem_gnt = 1'b0;
    d_gnt     = 1'b0;
    if (!i_rst) begin
      if (f_hit) begin
        d_gnt = i_d_valid;
      end else begin
        f_mem_gnt = i_f_valid && (!i_d_valid || starved);
        d_gnt     = i_d_valid && !f_mem_gnt;
      end
    end
  end

  assign o_f_ready = f_mem_gnt || f_hit;
  assign o_d_ready = d_gnt;
  assign o_m_valid = f_mem_gnt || d_gnt;
  assign o_m_we    = d_gnt && i_d_we;
  assign o_m_addr  = f_mem_gnt ? f_waddr : (d_gnt ? i_d_addr : '0);
  assign o_m_data  = (d_gnt && i_d_we) ? i_d_data : '0;

  always_comb begin
    tag_d = '{owner: OWNER_NONE, byte_sel: 2'b00};
    if (f_mem_gnt) begin
      tag_d = '{owner: OWNER_F, byte_sel: i_f_addr[1:0]};
    end else if (d_gnt && !i_d_we) begin
      tag_d.owner = OWNER_D;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
      tag_q      <= '{owner: OWNER_NONE, byte_sel: 2'b00};
      hit_q      <= 1'b0;
      hit_byte_q <= '0;
    end else begin
      if (!i_f_valid || o_f_ready) starve_cnt <= '0;
      else if (!starved)           starve_cnt <= starve_cnt + 4'd1;
      tag_q <= tag_d;
      hit_q <= f_hit;
      if (f_hit) hit_byte_q <= hit_byte;
    end
  end

  assign o_f_rvalid = (tag_q.owner == OWNER_F) || hit_q;
  assign o_d_rvalid = (tag_q.owner == OWNER_D);
  assign o_f_data   = hit_q ? hit_byte_q :
                      ((tag_q.owner == OWNER_F) ? sel_byte(i_m_data, tag_q.byte_sel) : f_hold_q);
  assign o_d_data   = o_d_rvalid ? i_m_data : d_hold_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (o_f_rvalid) f_hold_q <= o_f_data;
      if (o_d_rvalid) d_hold_q <= i_m_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps then random traffic against
// a behavioural model; buffer scenarios are included when HEX_FETCH_BUF_EN is defined.
module tb_mem_arbiter;
  import hex_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   f_valid = 1'b0, d_valid = 1'b0, d_we = 1'b0;
  iaddr_t f_addr = '0;
  waddr_t d_addr = '0;
  data_t  d_wdata = '0;
  logic   f_ready, f_rvalid, d_ready, d_rvalid, m_valid, m_we;
  instr_t f_rdata;
  data_t  d_rdata, m_wdata;
  data_t  m_rdata = '0;
  waddr_t m_addr;

  data_t env_mem [256] = '{default: '0};
  data_t ref_mem [256] = '{default: '0};

  int checks = 0;
  int failures = 0;

  // reference model state
  int unsigned denied = 0;
  logic   e_frv = 1'b0, e_drv = 1'b0;
  instr_t e_fdata = '0;
  data_t  e_ddata = '0;
  logic   bv = 1'b0, pl_v = 1'b0;
  waddr_t ba = '0, pl_a = '0;
  data_t  bw = '0, pl_w = '0;
  logic   m_fr, m_dr;

  logic   obs_f_ready, obs_d_ready, obs_m_valid, obs_m_we, obs_f_rvalid, obs_d_rvalid;
  waddr_t obs_m_addr;
  data_t  obs_m_data, obs_d_data;
  instr_t obs_f_data;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_f_valid(f_valid), .o_f_ready(f_ready), .i_f_addr(f_addr),
    .o_f_rvalid(f_rvalid), .o_f_data(f_rdata),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_we(d_we),
    .i_d_addr(d_addr), .i_d_data(d_wdata),
    .o_d_rvalid(d_rvalid), .o_d_data(d_rdata),
    .o_m_valid(m_valid), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_data(m_wdata),
    .i_m_data(m_rdata)
  );

  // Synchronous-read memory; garbage on the read bus when nothing is read.
  always @(posedge clk) begin
    m_rdata <= $urandom;
    if (m_valid && !m_we) m_rdata <= env_mem[m_addr];
    if (m_valid && m_we)  env_mem[m_addr] <= m_wdata;
  end

  function automatic instr_t pick(input data_t w, input logic [1:0] s);
    return instr_t'(w >> (8 * s));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic fv, input iaddr_t fa, input logic dv,
                       input logic dwe, input waddr_t da, input data_t dd);
    logic   hit, fg, dg, n_frv, n_drv;
    waddr_t fw;
    instr_t n_fb;
    data_t  n_dw;
    f_valid = fv; f_addr = fa; d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dd;
    fw = fa[WADDR_W+1:2];
    #4;
    if (rst) begin
      denied = 0; e_frv = 1'b0; e_drv = 1'b0; e_fdata = '0; e_ddata = '0;
      bv = 1'b0; pl_v = 1'b0;
    end
    hit = 1'b0;
`ifdef HEX_FETCH_BUF_EN
    hit = !rst && fv && bv && (ba == fw) && !(dv && dwe && (da == fw));
`endif
    if (rst) begin
      fg = 1'b0; dg = 1'b0; m_fr = 1'b0;
    end else if (hit) begin
      fg = 1'b0; dg = dv; m_fr = 1'b1;
    end else begin
      fg = fv && (!dv || denied == LIMIT); dg = dv && !fg; m_fr = fg;
    end
    m_dr = dg;

    obs_f_ready = f_ready; obs_d_ready = d_ready; obs_m_valid = m_valid; obs_m_we = m_we;
    obs_m_addr = m_addr; obs_m_data = m_wdata; obs_f_rvalid = f_rvalid;
    obs_d_rvalid = d_rvalid; obs_f_data = f_rdata; obs_d_data = d_rdata;

    chk("f_ready", f_ready, m_fr);
    chk("d_ready", d_ready, dg);
    chk("m_valid", m_valid, fg || dg);
    chk("m_we", m_we, dg && dwe);
    if (fg) chk("m_addr_f", m_addr, fw);
    if (dg) chk("m_addr_d", m_addr, da);
    if (dg && dwe) chk("m_data", m_wdata, dd);
    if (rst) begin
      chk("m_addr_rst", m_addr, 0);
      chk("m_data_rst", m_wdata, 0);
    end
    chk("f_rvalid", f_rvalid, e_frv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("f_data", f_rdata, e_fdata);
    chk("d_data", d_rdata, e_ddata);

    if (!rst) begin
      denied = (fv && !m_fr) ? ((denied < LIMIT) ? denied + 1 : denied) : 0;
      n_frv = hit || fg;
      n_fb  = hit ? pick(bw, fa[1:0]) : pick(ref_mem[fw], fa[1:0]);
      n_drv = dg && !dwe;
      n_dw  = ref_mem[da];
      if (pl_v) begin bv = 1'b1; ba = pl_a; bw = pl_w; end
      if (dg && dwe && bv && ba == da) bv = 1'b0;
      pl_v = fg; pl_a = fw; pl_w = ref_mem[fw];
      if (dg && dwe) ref_mem[da] = dd;
      e_frv = n_frv;
      if (n_frv) e_fdata = n_fb;
      e_drv = n_drv;
      if (n_drv) e_ddata = n_dw;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    logic       first_frv, first_drv;
    logic       fv_r, dv_r, dwe_r;
    iaddr_t     fa_r;
    waddr_t     da_r;
    data_t      dd_r;

    // reset state with requests asserted
    rst = 1'b1;
    cycle(1'b1, 10'h0D, 1'b1, 1'b1, 8'd3, 32'h1);
    chk("rst_f_ready", obs_f_ready, 0);
    chk("rst_d_ready", obs_d_ready, 0);
    chk("rst_m_valid", obs_m_valid, 0);
    chk("rst_f_data", obs_f_data, 0);
    chk("rst_d_data", obs_d_data, 0);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // fetch byte 1 of word 3
    cycle(1'b0, '0, 1'b1, 1'b1, 8'd3, 32'h44332211);
    chk("pre_we", obs_m_we, 1);
    cycle(1'b1, 10'h0D, 1'b0, 1'b0, '0, '0);
    chk("fetch_ready", obs_f_ready, 1);
    chk("fetch_maddr", obs_m_addr, 3);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("fetch_rvalid", obs_f_rvalid, 1);
    chk("fetch_byte", obs_f_data, 8'h22);

    // write then read word 5
    cycle(1'b0, '0, 1'b1, 1'b1, 8'd5, 32'hDEADBEEF);
    chk("wr_we", obs_m_we, 1);
    cycle(1'b0, '0, 1'b1, 1'b0, 8'd5, '0);
    chk("rd_we", obs_m_we, 0);
    chk("wr_no_resp", obs_d_rvalid, 0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("rd_rvalid", obs_d_rvalid, 1);
    chk("rd_data", obs_d_data, 32'hDEADBEEF);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("rd_idle", obs_d_rvalid, 0);
    chk("rd_hold", obs_d_data, 32'hDEADBEEF);

    // starvation: same-word write keeps the fetch off any buffer hit path
    pat = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      cycle(1'b1, 10'h0D, 1'b1, 1'b1, 8'd3, 32'h44332211);
      pat[i] = obs_f_ready;
    end
    chk("starve_pattern", pat, 10'h210);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // reset the cycle after a read grant, with the fetch already partly starved
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 10'h2C, 1'b1, 1'b0, 8'd5, '0);
    rst = 1'b1;
    cycle(1'b1, 10'h2C, 1'b1, 1'b0, 8'd5, '0);
    chk("mid_rst_d_rvalid", obs_d_rvalid, 0);
    chk("mid_rst_f_rvalid", obs_f_rvalid, 0);
    chk("mid_rst_m_we", obs_m_we, 0);
    chk("mid_rst_d_data", obs_d_data, 0);
    cycle(1'b1, 10'h2C, 1'b1, 1'b0, 8'd5, '0);
    rst = 1'b0;
    cycle(1'b1, 10'h2C, 1'b1, 1'b0, 8'd5, '0);
    first_frv = obs_f_rvalid;
    first_drv = obs_d_rvalid;
    pat = '0;
    pat[0] = obs_f_ready;
    for (int unsigned i = 1; i < 5; i++) begin
      cycle(1'b1, 10'h2C, 1'b1, 1'b0, 8'd5, '0);
      pat[i] = obs_f_ready;
    end
    chk("post_rst_frv", first_frv, 0);
    chk("post_rst_drv", first_drv, 0);
    chk("post_rst_pattern", pat, 10'h010);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);

`ifdef HEX_FETCH_BUF_EN
    cycle(1'b0, '0, 1'b1, 1'b1, 8'd4, 32'h88776655);
    cycle(1'b1, 10'h10, 1'b0, 1'b0, '0, '0);
    chk("buf_miss_maddr", obs_m_addr, 4);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("buf_fill_byte", obs_f_data, 8'h55);
    cycle(1'b1, 10'h11, 1'b1, 1'b0, 8'd5, '0);
    chk("buf_hit_fready", obs_f_ready, 1);
    chk("buf_hit_dready", obs_d_ready, 1);
    chk("buf_hit_maddr", obs_m_addr, 5);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("buf_hit_byte", obs_f_data, 8'h66);
    chk("buf_hit_drv", obs_d_rvalid, 1);
    cycle(1'b1, 10'h12, 1'b1, 1'b1, 8'd4, 32'hA1B2C3D4);
    chk("buf_wr_dready", obs_d_ready, 1);
    chk("buf_wr_fready", obs_f_ready, 0);
    cycle(1'b1, 10'h12, 1'b0, 1'b0, '0, '0);
    chk("buf_inv_mvalid", obs_m_valid, 1);
    chk("buf_inv_maddr", obs_m_addr, 4);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("buf_new_byte", obs_f_data, 8'hB2);
`endif

    // random traffic, requests held until accepted
    fv_r = 1'b0; dv_r = 1'b0; dwe_r = 1'b0; fa_r = '0; da_r = '0; dd_r = '0;
    m_fr = 1'b1; m_dr = 1'b1;
    for (int unsigned n = 0; n < 3000; n++) begin
      if (!fv_r || m_fr || rst) begin
        fv_r = ($urandom_range(0, 3) != 0);
        fa_r = iaddr_t'($urandom_range(0, 31));
      end
      if (!dv_r || m_dr || rst) begin
        dv_r  = ($urandom_range(0, 1) != 0);
        dwe_r = ($urandom_range(0, 2) == 0);
        da_r  = waddr_t'($urandom_range(0, 7));
        dd_r  = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle(fv_r, fa_r, dv_r, dwe_r, da_r, dd_r);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, synchronous-read memory between the processor instruction-fetch port and data port.
- Sits between `processor` and `memory` inside the `hex` top.
- Fixed-priority arbitration (data over fetch) with a fetch anti-starvation counter.
- Routes the 1-cycle-latency memory read data back to the granted requester and extracts the instruction byte for fetches.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a pending fetch may be denied before it is force-granted over data. Range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_f_valid  in  1  fetch request
- o_f_ready  out  1  fetch request accepted this cycle
- i_f_addr  in  hex_pkg::iaddr_t  byte address of instruction
- o_f_rvalid  out  1  fetch response valid
- o_f_data  out  hex_pkg::instr_t  fetched instruction byte
- i_d_valid  in  1  data request
- o_d_ready  out  1  data request accepted this cycle
- i_d_we  in  1  data write enable
- i_d_addr  in  hex_pkg::waddr_t  data word address
- i_d_data  in  hex_pkg::data_t  write data
- o_d_rvalid  out  1  data read response valid
- o_d_data  out  hex_pkg::data_t  read data
- o_m_valid  out  1  memory access
- o_m_we  out  1  memory write
- o_m_addr  out  hex_pkg::waddr_t  memory word address
- o_m_data  out  hex_pkg::data_t  memory write data
- i_m_data  in  hex_pkg::data_t  memory read data, valid the cycle after a read access

Behaviour:
- Clock and reset:
  - Single clock, i_clk. Reset i_rst is asynchronous and active-high.
  - In reset: o_f_ready, o_d_ready, o_f_rvalid, o_d_rvalid, o_m_valid and o_m_we are 0. o_m_addr, o_m_data, o_f_data and o_d_data are 0.
  - Reset clears the starvation counter, the response tag and the fetch buffer. Reset mid-transaction drops any in-flight response; no rvalid fires after reset release for a pre-reset grant.
- Handshake:
  - A requester holds valid and its address/data stable until ready=1 in the same cycle.
  - Grant is combinational in the request cycle. At most one memory access per cycle.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle i_f_valid && !o_f_ready.
  - Clears on a fetch grant, or when i_f_valid=0.
- Memory drive on grant: o_m_valid=1. For a data grant, o_m_we=i_d_we. For a fetch, o_m_addr=i_f_addr[msb:2]; for data, o_m_addr=i_d_addr.
- Response (registered tag {owner, byte_sel}):
  - Exactly one cycle after a read grant, the owner's rvalid=1 for one cycle.
  - o_d_data = i_m_data.
  - o_f_data = i_m_data[8*byte_sel +: 8], little-endian byte order; byte_sel = i_f_addr[1:0].
  - Writes produce no response.
- Back-to-back grants every cycle are allowed; the response for grant N appears in cycle N+1.
- When not valid, rvalid outputs are 0 and data outputs hold their last value.

Optional Feature:
- Macro: HEX_FETCH_BUF_EN.
- Defined:
  - A one-word fetch buffer {valid, waddr, word} is loaded on every fetch response.
  - Fetch hit (buffer valid and matching word address): o_f_ready=1 with no memory access. o_f_rvalid the next cycle, byte taken from the buffer.
  - A hit does not consume the port: a data request in the same cycle is granted concurrently.
  - A hit clears starve_cnt.
  - Any granted data write to the buffered word invalidates the buffer.
  - A fetch hit coincident with a granted write to the same word is treated as a miss and arbitrated normally, so it observes the new data.
- Undefined: every fetch accesses memory. Behaviour is as above with no buffer.

Decomposition:
- hex_pkg gains:
  - owner_e {OWNER_NONE, OWNER_F, OWNER_D}
  - FETCH_BYTES=4
  - resp_tag_t {owner_e owner; logic [1:0] byte_sel}
- iaddr_t is defined as waddr_t width + 2.
- One sub-module, mem_arb_fetch_buf, holding the buffer register, hit compare and invalidate. It is instantiated only under HEX_FETCH_BUF_EN.

Test Plan:
- Fetch only, i_f_addr=0x0D, memory word 3 = 0x44332211 -> o_m_addr=3, o_f_rvalid next cycle, o_f_data=0x22.
- Data write 0xDEADBEEF to addr 5, then data read addr 5 -> o_m_we=1 then 0; o_d_rvalid one cycle after the read grant with 0xDEADBEEF; no rvalid for the write.
- Fetch and data both valid continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant; the pattern repeats.
- Assert i_rst the cycle after a read grant -> no rvalid after release; all outputs 0 during reset; the first post-reset fetch is granted with starve_cnt=0.
- HEX_FETCH_BUF_EN, fetch addrs 0x10 then 0x11 -> one memory access only. The second fetch is granted while a concurrent data read is also granted.
- HEX_FETCH_BUF_EN, buffered word 4, data write to addr 4 plus a same-cycle fetch 0x12 -> write granted first; the fetch then accesses memory and returns the new byte.
